// File: rtl/rr_encoder_pkg.sv
// rr_encoder shared definitions.
// FSM state encoding and handshake counter width.
package rr_encoder_pkg;

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   localparam int CNT_W = 16;

endpackage

// File: rtl/rr_encoder_pick.sv
// rr_encoder winner search.
// Round-robin from ptr, or fixed highest-index-wins.
module rr_encoder_pick
   import rr_encoder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int RR    = 1,
   parameter int OUT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] req,
   input  logic [OUT_W-1:0] ptr,
   output logic [OUT_W-1:0] win,
   output logic             any
);

   int j;

   // Select the winning index; smallest offset from ptr wins in RR mode
   always_comb begin
      win = '0;
      any = |req;
      j   = 0;
      if (RR != 0) begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            j = int'(ptr) + i;
            if (j >= WIDTH) j = j - WIDTH;
            if (req[j]) win = OUT_W'(j);
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (req[i]) win = OUT_W'(i);
         end
      end
   end

endmodule

// File: rtl/rr_encoder.sv
// rr_encoder: registered request arbiter with valid/ready output.
// Optional handshake counter enabled by RR_ENCODER_CNT_EN.
module rr_encoder
   import rr_encoder_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int RR    = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [WIDTH-1:0]         req,
   input  logic                     ready,
   output logic [$clog2(WIDTH)-1:0] out,
   output logic                     valid
`ifdef RR_ENCODER_CNT_EN
   ,
   output logic [CNT_W-1:0]         grant_cnt
`endif
);

   localparam int OUT_W = $clog2(WIDTH);

   logic [0:0]       state;
   logic [OUT_W-1:0] ptr;
   logic [OUT_W-1:0] ptr_inc;
   logic [OUT_W-1:0] ptr_src;
   logic [OUT_W-1:0] win;
   logic             any;
   logic             hs;

   assign valid   = (state == GRANT);
   assign hs      = valid & ready;
   assign ptr_inc = (out == OUT_W'(WIDTH - 1)) ? '0
                                              : out + OUT_W'(1);
   // Back-to-back grants search from the post-handshake pointer
   assign ptr_src = hs ? ptr_inc : ptr;

   rr_encoder_pick #(
      .WIDTH (WIDTH),
      .RR    (RR),
      .OUT_W (OUT_W)
   ) u_pick (
      .req (req),
      .ptr (ptr_src),
      .win (win),
      .any (any)
   );

   // Grant FSM with pointer and winner registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         out   <= '0;
         ptr   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any) begin
                  out   <= win;
                  state <= GRANT;
               end
            end
            GRANT: begin
               if (ready) begin
                  if (RR != 0) ptr <= ptr_inc;
                  if (any) out <= win;
                  else     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef RR_ENCODER_CNT_EN
   // Saturating count of accepted grants
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else if (hs && (grant_cnt != '1)) begin
         grant_cnt <= grant_cnt + CNT_W'(1);
      end
   end
`else
   // Handshake counter not present in this build
`endif

endmodule

// File: tb/tb_rr_encoder.sv
// rr_encoder bench: RR=1 and RR=0 instances on shared stimulus,
// reference model plus hand-computed expectations.
module tb_rr_encoder;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       ready;
   logic [2:0] rr_out;
   logic       rr_valid;
   logic [2:0] fx_out;
   logic       fx_valid;

   int errors = 0;
   int checks = 0;

   int m_out [2];
   int m_val [2];
   int m_ptr [2];

   int seen [8];

   rr_encoder #(.WIDTH(8), .RR(1)) u_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .ready (ready),
      .out   (rr_out),
      .valid (rr_valid)
   );

   rr_encoder #(.WIDTH(8), .RR(0)) u_fx (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req),
      .ready (ready),
      .out   (fx_out),
      .valid (fx_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Winner from the arbitration rules; m=1 round-robin, m=0 fixed
   function automatic int pick(input logic [7:0] r, input int p,
                               input int m);
      if (m == 1) begin
         for (int k = 0; k < 8; k++) begin
            if (r[(p + k) % 8]) return (p + k) % 8;
         end
      end else begin
         for (int k = 7; k >= 0; k--) begin
            if (r[k]) return k;
         end
      end
      return 0;
   endfunction

   // Reference model, one slot per arbitration mode
   always @(posedge clk or negedge rst_n) begin
      int np;
      np = 0;
      if (!rst_n) begin
         for (int m = 0; m < 2; m++) begin
            m_out[m] <= 0;
            m_val[m] <= 0;
            m_ptr[m] <= 0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            if (m_val[m] == 0) begin
               if (req != 8'h00) begin
                  m_out[m] <= pick(req, m_ptr[m], m);
                  m_val[m] <= 1;
               end
            end else if (ready) begin
               np = (m == 1) ? (m_out[m] + 1) % 8 : 0;
               m_ptr[m] <= np;
               if (req != 8'h00) m_out[m] <= pick(req, np, m);
               else              m_val[m] <= 0;
            end
         end
      end
   end

   // Compare both instances against the model every cycle
   always @(negedge clk) begin
      chk("rr_valid_model", int'(rr_valid), m_val[1]);
      chk("rr_out_model",   int'(rr_out),   m_out[1]);
      chk("fx_valid_model", int'(fx_valid), m_val[0]);
      chk("fx_out_model",   int'(fx_out),   m_out[0]);
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int rr_seq [5];
      rr_seq = '{3, 5, 7, 1, 3};
      rst_n = 1'b0;
      req   = 8'h00;
      ready = 1'b0;

      #12;
      chk("reset_rr_out",   int'(rr_out),   0);
      chk("reset_rr_valid", int'(rr_valid), 0);
      chk("reset_fx_valid", int'(fx_valid), 0);

      // Single request, then ptr=4 shown by next search
      rst_n = 1'b1;
      req   = 8'b0000_1000;
      ready = 1'b1;
      tick();
      chk("single_rr_out",   int'(rr_out),   3);
      chk("single_rr_valid", int'(rr_valid), 1);
      chk("single_fx_out",   int'(fx_out),   3);
      chk("model_pin_out",   m_out[1],       3);
      req = 8'h00;
      tick();
      chk("drop_rr_valid", int'(rr_valid), 0);
      chk("drop_fx_valid", int'(fx_valid), 0);
      req   = 8'b0001_1001;
      ready = 1'b0;
      tick();
      chk("ptr4_rr_out", int'(rr_out), 4);
      chk("ptr4_fx_out", int'(fx_out), 4);

      // Round-robin sequence and fixed priority on 10101010
      pulse_reset();
      req   = 8'b1010_1010;
      ready = 1'b1;
      tick();
      chk("seq_rr_out0", int'(rr_out), 1);
      chk("seq_fx_out0", int'(fx_out), 7);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("seq_rr_out", int'(rr_out), rr_seq[i]);
         chk("seq_fx_out", int'(fx_out), 7);
         chk("seq_fx_valid", int'(fx_valid), 1);
      end
      tick();
      tick();
      chk("hold_pre_rr_out", int'(rr_out), 7);

      // Stall with changing req, then wrap to 0
      ready = 1'b0;
      req   = 8'b0000_0001;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_rr_out",   int'(rr_out),   7);
         chk("stall_rr_valid", int'(rr_valid), 1);
         chk("stall_fx_out",   int'(fx_out),   7);
      end
      req = 8'h00;
      tick();
      chk("stall_zero_rr_valid", int'(rr_valid), 1);
      chk("stall_zero_rr_out",   int'(rr_out),   7);
      req   = 8'b0000_0001;
      ready = 1'b1;
      tick();
      chk("wrap_rr_out",   int'(rr_out),   0);
      chk("wrap_rr_valid", int'(rr_valid), 1);
      chk("wrap_fx_out",   int'(fx_out),   0);
      req = 8'h00;
      tick();
      chk("idle_rr_valid", int'(rr_valid), 0);
      tick();
      chk("ign_rr_valid", int'(rr_valid), 0);
      chk("ign_rr_out",   int'(rr_out),   0);

      // Asynchronous reset mid-grant
      req   = 8'b0100_0000;
      ready = 1'b0;
      tick();
      chk("pre_rst_rr_out", int'(rr_out), 6);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rr_out",   int'(rr_out),   0);
      chk("async_rr_valid", int'(rr_valid), 0);
      chk("async_fx_out",   int'(fx_out),   0);
      chk("async_fx_valid", int'(fx_valid), 0);
      tick();
      chk("held_rst_valid", int'(rr_valid), 0);
      #1;
      rst_n = 1'b1;
      req   = 8'b0000_0001;
      tick();
      chk("post_rst_rr_out",   int'(rr_out),   0);
      chk("post_rst_rr_valid", int'(rr_valid), 1);
      chk("post_rst_fx_valid", int'(fx_valid), 1);

      // Fairness with all requests held
      pulse_reset();
      for (int i = 0; i < 8; i++) seen[i] = 0;
      req   = 8'hFF;
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (rr_valid) seen[rr_out]++;
      end
      for (int i = 0; i < 8; i++) begin
         chk("fair_count", seen[i], 1);
      end

      ready = 1'b0;
      req   = 8'h00;
      tick();
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
